// File: rtl/operand_sequencer.sv
// operand_sequencer: debounced button front-end that collects A, B and select, strobes the ALU and captures its result
module operand_sequencer #(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] sw,
  input  logic             enter,
  input  logic             abort,
  input  logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [3:0]       select,
  output logic             do_o,
  output logic [WIDTH-1:0] result,
  output logic             result_valid,
  output logic             busy,
  output logic [2:0]       phase
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  typedef enum logic [2:0] {
    S_A    = 3'b000,
    S_B    = 3'b001,
    S_OP   = 3'b010,
    S_EXEC = 3'b011,
    S_WAIT = 3'b100,
    S_SHOW = 3'b101
  } state_t;
  state_t           state_q, state_d;
  logic             sync1_q, sync_q, deb_q, deb_d, deb_prev_q, press_q;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, result_q, result_d;
  logic [3:0]       sel_q, sel_d;
  logic             do_q, do_d, rv_q, rv_d;
  // A level change is accepted only after it has differed for DEBOUNCE_CYCLES consecutive cycles
  always_comb begin
    cnt_d = '0;
    deb_d = deb_q;
    if (sync_q != deb_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) deb_d = sync_q;
      else cnt_d = cnt_q + CW'(1);
    end
  end
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    sel_d    = sel_q;
    result_d = result_q;
    rv_d     = rv_q;
    if (abort) begin
      state_d = S_A;
      rv_d    = 1'b0;
    end else begin
      case (state_q)
        S_A: if (press_q) begin
          a_d     = sw;
          state_d = S_B;
        end
        S_B: if (press_q) begin
          b_d     = sw;
          state_d = S_OP;
        end
        S_OP: if (press_q) begin
          sel_d   = sw[3:0];
          state_d = S_EXEC;
        end
        S_EXEC: state_d = S_WAIT;
        S_WAIT: begin
          result_d = y;
          rv_d     = 1'b1;
          state_d  = S_SHOW;
        end
        S_SHOW: if (press_q) begin
          rv_d    = 1'b0;
          state_d = S_A;
        end
        default: state_d = S_A;
      endcase
    end
    do_d = (state_d == S_EXEC);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q    <= 1'b0;
      sync_q     <= 1'b0;
      deb_q      <= 1'b0;
      deb_prev_q <= 1'b0;
      press_q    <= 1'b0;
      cnt_q      <= '0;
      state_q    <= S_A;
      a_q        <= '0;
      b_q        <= '0;
      sel_q      <= '0;
      result_q   <= '0;
      do_q       <= 1'b0;
      rv_q       <= 1'b0;
    end else begin
      sync1_q    <= enter;
      sync_q     <= sync1_q;
      deb_q      <= deb_d;
      deb_prev_q <= deb_q;
      press_q    <= deb_q & ~deb_prev_q;
      cnt_q      <= cnt_d;
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      sel_q      <= sel_d;
      result_q   <= result_d;
      do_q       <= do_d;
      rv_q       <= rv_d;
    end
  end
  assign a            = a_q;
  assign b            = b_q;
  assign select       = sel_q;
  assign do_o         = do_q;
  assign result       = result_q;
  assign result_valid = rv_q;
  assign busy         = (state_q == S_EXEC) || (state_q == S_WAIT);
  assign phase        = state_q;
endmodule

// File: tb/tb_operand_sequencer.sv
// tb_operand_sequencer: random transactions against a behavioural ALU and transaction-level scoreboard
module tb_operand_sequencer;
  logic       clk = 1'b0, reset = 1'b1, enter = 1'b0, abort = 1'b0;
  logic [7:0] sw = '0, y, a, b, result;
  logic [3:0] select;
  logic       do_o, result_valid, busy;
  logic [2:0] phase;
  int         checks = 0, failures = 0, do_cnt = 0;
  logic       prev_do = 1'b0;
  logic [7:0] exp_prev = '0;
  operand_sequencer #(.WIDTH(8), .DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .sw(sw), .enter(enter), .abort(abort), .y(y),
    .a(a), .b(b), .select(select), .do_o(do_o), .result(result),
    .result_valid(result_valid), .busy(busy), .phase(phase)
  );
  always #5 clk = ~clk;
  function automatic logic [7:0] alu(input logic [7:0] x, input logic [7:0] z, input logic [3:0] s);
    case (s)
      4'd0:  return x + z;
      4'd1:  return x - z;
      4'd2:  return x & z;
      4'd3:  return x | z;
      4'd4:  return x ^ z;
      4'd5:  return ~x;
      4'd6:  return x << 1;
      4'd7:  return x >> 1;
      4'd8:  return x + 8'd1;
      4'd9:  return x - 8'd1;
      4'd10: return x;
      4'd11: return z;
      4'd12: return 8'd0 - x;
      default: return 8'd0;
    endcase
  endfunction
  // Registered ALU: captures on the strobe, selects 13..15 leave Y alone
  always @(posedge clk)
    if (reset) y <= '0;
    else if (do_o && select < 4'd13) y <= alu(a, b, select);
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask
  always @(negedge clk)
    if (!reset) begin
      if (do_o) begin
        do_cnt++;
        chk("do_phase", 32'(phase), 32'd3);
        chk("do_single", 32'(prev_do), 32'd0);
      end
      prev_do = do_o;
    end
  task automatic press(input logic [7:0] v);
    @(negedge clk);
    sw    = v;
    enter = 1'b1;
    repeat (12) @(negedge clk);
    enter = 1'b0;
    repeat (12) @(negedge clk);
  endtask
  task automatic do_abort();
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
  endtask
  task automatic txn(input logic [7:0] va, input logic [7:0] vb, input logic [7:0] vs);
    int d0;
    logic [7:0] want;
    press(va);
    chk("txn_phase_b", 32'(phase), 32'd1);
    press(vb);
    chk("txn_phase_op", 32'(phase), 32'd2);
    d0 = do_cnt;
    press(vs);
    want = (vs[3:0] < 4'd13) ? alu(va, vb, vs[3:0]) : exp_prev;
    exp_prev = want;
    chk("txn_phase_show", 32'(phase), 32'd5);
    chk("txn_rv", 32'(result_valid), 32'd1);
    chk("txn_result", 32'(result), 32'(want));
    chk("txn_a", 32'(a), 32'(va));
    chk("txn_b", 32'(b), 32'(vb));
    chk("txn_sel", 32'(select), 32'(vs[3:0]));
    chk("txn_do_count", 32'(do_cnt - d0), 32'd1);
    chk("txn_busy", 32'(busy), 32'd0);
  endtask
  task automatic clear();
    logic [7:0] r;
    r = result;
    press(8'h00);
    chk("clr_phase", 32'(phase), 32'd0);
    chk("clr_rv", 32'(result_valid), 32'd0);
    chk("clr_result_held", 32'(result), 32'(r));
  endtask
  initial begin
    int k, d0;
    repeat (3) @(negedge clk);
    chk("rst_a", 32'(a), 0);
    chk("rst_b", 32'(b), 0);
    chk("rst_sel", 32'(select), 0);
    chk("rst_do", 32'(do_o), 0);
    chk("rst_result", 32'(result), 0);
    chk("rst_rv", 32'(result_valid), 0);
    chk("rst_phase", 32'(phase), 0);
    chk("rst_busy", 32'(busy), 0);
    reset = 1'b0;
    txn(8'h05, 8'h03, 8'h00);
    chk("add_result", 32'(result), 32'h08);
    clear();
    txn(8'h03, 8'h05, 8'h01);
    chk("sub_result", 32'(result), 32'hFE);
    clear();
    // Bounce: toggling every 2 cycles must never be accepted
    @(negedge clk);
    sw = 8'h77;
    for (int i = 0; i < 10; i++) begin
      enter = ~enter;
      repeat (2) @(negedge clk);
    end
    chk("bounce_no_press", 32'(phase), 32'd0);
    enter = 1'b1;
    k = 0;
    while (phase == 3'd0 && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("bounce_latency", 32'(k), 32'd8);
    repeat (12) @(negedge clk);
    enter = 1'b0;
    repeat (12) @(negedge clk);
    chk("bounce_single", 32'(phase), 32'd1);
    chk("bounce_a", 32'(a), 32'h77);
    do_abort();
    chk("abort_b_phase", 32'(phase), 32'd0);
    // Abort in S_OP
    press(8'h05);
    press(8'h09);
    chk("op_reached", 32'(phase), 32'd2);
    d0 = do_cnt;
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_phase", 32'(phase), 32'd0);
    chk("abort_a", 32'(a), 32'h05);
    repeat (10) @(negedge clk);
    chk("abort_no_do", 32'(do_cnt - d0), 32'd0);
    chk("abort_rv", 32'(result_valid), 32'd0);
    // Reset in S_WAIT with enter held through reset
    press(8'h01);
    press(8'h02);
    @(negedge clk);
    sw    = 8'h02;
    enter = 1'b1;
    k = 0;
    while (phase != 3'd4 && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("wait_reached", 32'(phase), 32'd4);
    reset = 1'b1;
    @(negedge clk);
    chk("rw_a", 32'(a), 0);
    chk("rw_b", 32'(b), 0);
    chk("rw_sel", 32'(select), 0);
    chk("rw_do", 32'(do_o), 0);
    chk("rw_result", 32'(result), 0);
    chk("rw_rv", 32'(result_valid), 0);
    chk("rw_phase", 32'(phase), 0);
    chk("rw_busy", 32'(busy), 0);
    exp_prev = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    k = 0;
    while (phase == 3'd0 && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("held_press", 32'(phase), 32'd1);
    repeat (12) @(negedge clk);
    enter = 1'b0;
    repeat (12) @(negedge clk);
    chk("held_single", 32'(phase), 32'd1);
    chk("held_a", 32'(a), 32'h02);
    do_abort();
    // Button activity during S_EXEC/S_WAIT is dropped
    press(8'h10);
    press(8'h20);
    d0 = do_cnt;
    @(negedge clk);
    sw    = 8'h00;
    enter = 1'b1;
    k = 0;
    while (phase != 3'd3 && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("exec_reached", 32'(phase), 32'd3);
    for (int i = 0; i < 6; i++) begin
      enter = ~enter;
      @(negedge clk);
    end
    enter = 1'b0;
    repeat (15) @(negedge clk);
    exp_prev = 8'h30;
    chk("exec_phase", 32'(phase), 32'd5);
    chk("exec_rv", 32'(result_valid), 32'd1);
    chk("exec_result", 32'(result), 32'h30);
    chk("exec_do_count", 32'(do_cnt - d0), 32'd1);
    clear();
    for (int i = 0; i < 8; i++) begin
      txn(8'($urandom), 8'($urandom), {4'($urandom), 4'($urandom_range(0, 15))});
      clear();
    end
    txn(8'h11, 8'h22, 8'h0E);
    clear();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
